// File: rtl/switch_debounce_if.sv
// Front-panel switch bundle: raw active-low switches in, debounced levels/pulses/LED drive out.
interface switch_debounce_if;
  logic sw1_i;
  logic sw2_i;
  logic state1_o;
  logic state2_o;
  logic press1_o;
  logic press2_o;
  logic release1_o;
  logic release2_o;
  logic long1_o;
  logic long2_o;
  logic led1_o;
  logic led2_o;

  modport master (
    output sw1_i, sw2_i,
    input  state1_o, state2_o, press1_o, press2_o, release1_o, release2_o,
    input  long1_o, long2_o, led1_o, led2_o
  );

  modport slave (
    input  sw1_i, sw2_i,
    output state1_o, state2_o, press1_o, press2_o, release1_o, release2_o,
    output long1_o, long2_o, led1_o, led2_o
  );
endinterface

// File: rtl/switch_debounce.sv
// Two-channel switch synchroniser/debouncer with press/release pulses and LED mirroring.
// Optional long-press detection is built only when LONG_PRESS_EN is defined.
module switch_debounce #(
  parameter int unsigned DB_CYCLES   = 100000,
  parameter int unsigned LONG_CYCLES = 10000000
) (
  input  logic             clk,
  input  logic             rst_n,
  switch_debounce_if.slave bus
);

  localparam int unsigned NCH    = 2;
  localparam int unsigned DB_W   = 20;
  localparam int unsigned LONG_W = 24;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  if (DB_CYCLES < 2 || DB_CYCLES > 32'hF_FFFF) begin : g_bad_db
    $error("switch_debounce: DB_CYCLES out of range");
  end
  if (LONG_CYCLES < 2 || LONG_CYCLES > 32'hFF_FFFF) begin : g_bad_long
    $error("switch_debounce: LONG_CYCLES out of range");
  end

  logic [NCH-1:0]  sw_n;
  logic [NCH-1:0]  sync1_q, sync2_q;
  logic [NCH-1:0]  state_q, state_d;
  logic [NCH-1:0]  press_q, press_d;
  logic [NCH-1:0]  rel_q, rel_d;
  logic [NCH-1:0]  long_q;
  logic [DB_W-1:0] db_cnt_q [NCH];
  logic [DB_W-1:0] db_cnt_d [NCH];

  assign sw_n = {bus.sw2_i, bus.sw1_i};

  // Count consecutive samples that disagree with the accepted level.
  always_comb begin
    state_d = state_q;
    press_d = '0;
    rel_d   = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      db_cnt_d[ch] = db_cnt_q[ch];
      if (sync2_q[ch] == state_q[ch]) begin
        db_cnt_d[ch] = '0;
      end else if (db_cnt_q[ch] == DB_LAST) begin
        state_d[ch]  = ~state_q[ch];
        db_cnt_d[ch] = '0;
        press_d[ch]  = sync2_q[ch];
        rel_d[ch]    = ~sync2_q[ch];
      end else begin
        db_cnt_d[ch] = db_cnt_q[ch] + DB_W'(1);
      end
    end
  end

  // Synchroniser is inverted at the input so 1 means pressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      state_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      for (int ch = 0; ch < NCH; ch++) db_cnt_q[ch] <= '0;
    end else begin
      sync1_q <= ~sw_n;
      sync2_q <= sync1_q;
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      for (int ch = 0; ch < NCH; ch++) db_cnt_q[ch] <= db_cnt_d[ch];
    end
  end

`ifdef LONG_PRESS_EN
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_PRE  = LONG_W'(LONG_CYCLES - 2);

  logic [NCH-1:0]    long_d;
  logic [LONG_W-1:0] long_cnt_q [NCH];
  logic [LONG_W-1:0] long_cnt_d [NCH];

  // Hold timer saturates so a single press yields at most one pulse.
  always_comb begin
    long_d = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      long_cnt_d[ch] = long_cnt_q[ch];
      if (!state_q[ch]) begin
        long_cnt_d[ch] = '0;
      end else if (long_cnt_q[ch] != LONG_LAST) begin
        long_cnt_d[ch] = long_cnt_q[ch] + LONG_W'(1);
        long_d[ch]     = (long_cnt_q[ch] == LONG_PRE);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_q <= '0;
      for (int ch = 0; ch < NCH; ch++) long_cnt_q[ch] <= '0;
    end else begin
      long_q <= long_d;
      for (int ch = 0; ch < NCH; ch++) long_cnt_q[ch] <= long_cnt_d[ch];
    end
  end
`else
  assign long_q = '0;
`endif

  assign bus.state1_o   = state_q[0];
  assign bus.state2_o   = state_q[1];
  assign bus.press1_o   = press_q[0];
  assign bus.press2_o   = press_q[1];
  assign bus.release1_o = rel_q[0];
  assign bus.release2_o = rel_q[1];
  assign bus.long1_o    = long_q[0];
  assign bus.long2_o    = long_q[1];
  assign bus.led1_o     = state_q[0];
  assign bus.led2_o     = state_q[1];

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce: expected pulses are queued with their edge number,
// a negedge monitor pops and checks every pulse the DUT emits.
module tb_switch_debounce;
  localparam int unsigned DB = 8;
  localparam int unsigned LC = 32;
  localparam int LAT  = 10;  // driver negedge -> output edge
  localparam int LLAT = 41;  // driver negedge -> LONG edge

  localparam int C_P1 = 11, C_R1 = 12, C_L1 = 13;
  localparam int C_P2 = 21, C_R2 = 22, C_L2 = 23;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  switch_debounce_if dif();

  switch_debounce #(.DB_CYCLES(DB), .LONG_CYCLES(LC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (dif.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int cyc;
    int code;
  } exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;

  task automatic expect_ev(input int at, input int code);
    exp_t e;
    e.cyc  = at;
    e.code = code;
    q.push_back(e);
  endtask

  task automatic check_pulse(input int code, input logic v);
    exp_t e;
    if (v) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL pulse: got code=%0d at cyc=%0d, required no pulse", code, cyc);
      end else begin
        e = q.pop_front();
        if (e.code != code || e.cyc != cyc) begin
          bad++;
          $display("FAIL pulse: got code=%0d at cyc=%0d, required code=%0d at cyc=%0d",
                   code, cyc, e.code, e.cyc);
        end
      end
    end
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      check_pulse(C_P1, dif.press1_o);
      check_pulse(C_R1, dif.release1_o);
      check_pulse(C_L1, dif.long1_o);
      check_pulse(C_P2, dif.press2_o);
      check_pulse(C_R2, dif.release2_o);
      check_pulse(C_L2, dif.long2_o);
    end
  end

  task automatic check_lvl(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b, required %b (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_lvl({tag, "_state1"}, dif.state1_o, 1'b0);
    check_lvl({tag, "_state2"}, dif.state2_o, 1'b0);
    check_lvl({tag, "_led1"},   dif.led1_o,   1'b0);
    check_lvl({tag, "_led2"},   dif.led2_o,   1'b0);
    check_lvl({tag, "_press1"}, dif.press1_o, 1'b0);
    check_lvl({tag, "_long1"},  dif.long1_o,  1'b0);
  endtask

  task automatic expect_long(input int at, input int code);
`ifdef LONG_PRESS_EN
    expect_ev(at, code);
`else
    if (at < 0 || code < 0) $display("note: negative expectation");
`endif
  endtask

  initial begin
    dif.sw1_i = 1'b1;
    dif.sw2_i = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_all_zero("reset");
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(3);

    // Single press on channel 1, with latency boundary checks.
    dif.sw1_i = 1'b0;
    expect_ev(cyc + LAT, C_P1);
    expect_long(cyc + LLAT, C_L1);
    wait_cyc(LAT - 1);
    check_lvl("press_early_state1", dif.state1_o, 1'b0);
    wait_cyc(1);
    check_lvl("press_state1", dif.state1_o, 1'b1);
    check_lvl("press_led1",   dif.led1_o,   1'b1);
    check_lvl("press_state2", dif.state2_o, 1'b0);
    wait_cyc(45);

    // Release of channel 1.
    dif.sw1_i = 1'b1;
    expect_ev(cyc + LAT, C_R1);
    wait_cyc(20);
    check_lvl("release_state1", dif.state1_o, 1'b0);
    check_lvl("release_led1",   dif.led1_o,   1'b0);

    // Glitches one cycle shorter than the debounce window never get accepted.
    repeat (5) begin
      dif.sw1_i = 1'b0;
      wait_cyc(7);
      dif.sw1_i = 1'b1;
      wait_cyc(1);
    end
    wait_cyc(20);
    check_lvl("glitch_state1", dif.state1_o, 1'b0);

    // Both channels pressed on the same edge, then reset mid-hold.
    dif.sw1_i = 1'b0;
    dif.sw2_i = 1'b0;
    expect_ev(cyc + LAT, C_P1);
    expect_ev(cyc + LAT, C_P2);
    expect_long(cyc + LLAT, C_L1);
    expect_long(cyc + LLAT, C_L2);
    wait_cyc(50);
    check_lvl("both_state1", dif.state1_o, 1'b1);
    check_lvl("both_state2", dif.state2_o, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_all_zero("hold_rst");
    dif.sw1_i = 1'b1;
    dif.sw2_i = 1'b1;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(15);
    check_lvl("post_rst_state2", dif.state2_o, 1'b0);

    // Reset while channel 1 is mid-debounce (count = 5), switch held through reset.
    dif.sw1_i = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_all_zero("db_rst");
    wait_cyc(3);
    rst_n = 1'b1;
    expect_ev(cyc + LAT, C_P1);
    expect_long(cyc + LLAT, C_L1);
    wait_cyc(LAT - 1);
    check_lvl("rst_early_state1", dif.state1_o, 1'b0);
    wait_cyc(1);
    check_lvl("rst_state1", dif.state1_o, 1'b1);
    wait_cyc(45);
    dif.sw1_i = 1'b1;
    expect_ev(cyc + LAT, C_R1);
    wait_cyc(20);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0 (next code=%0d cyc=%0d)",
               q.size(), q[0].code, q[0].cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/switch_debounce.md
# switch_debounce

Two-channel pushbutton/jumper input reader for the RefLock II CPLD; it complements the LED outputs on the input side of the front panel. Raw active-low switch inputs are synchronised, debounced by a per-channel consecutive-sample counter, and presented as clean levels plus single-cycle press/release pulses. The debounced levels also drive LED1/LED2 directly, so the board gives visible switch feedback with no other logic.

## Interface
- DB_CYCLES, 100000: consecutive stable cycles required to accept a change (10 ms at 10 MHz); legal range 2..2^20-1.
- LONG_CYCLES, 10000000: held-pressed cycles before LONG pulse (1 s at 10 MHz); legal range 2..2^24-1.
- CLK  in  1  system clock (10 MHz reference domain).
- RESET_N  in  1  asynchronous, active-low reset.
- SW1, SW2  in  1 each  raw switch inputs, active-low (0 = pressed), asynchronous to CLK.
- STATE1, STATE2  out  1 each  debounced level, active-high (1 = pressed).
- PRESS1, PRESS2  out  1 each  one-cycle pulse on accepted press.
- RELEASE1, RELEASE2  out  1 each  one-cycle pulse on accepted release.
- LONG1, LONG2  out  1 each  one-cycle pulse when hold reaches LONG_CYCLES (see Configuration).
- LED1, LED2  out  1 each  active-high LED drive, equal to STATE1/STATE2.

## Operation
- Channels are identical and fully independent; no shared state.
- Synchroniser: two flops per channel, inverted at input so sync value 1 = pressed; both reset to 0.
- Debounce counter (20 bits) per channel, each rising edge:
  - sync == STATE: counter cleared.
  - sync != STATE and counter == DB_CYCLES-1: STATE toggles, counter cleared, PRESS (new STATE 1) or RELEASE (new STATE 0) asserted for exactly this one registered cycle.
  - otherwise counter increments.
- Any single sample where sync equals STATE restarts the count: glitches shorter than DB_CYCLES cycles never change STATE.
- PRESS and RELEASE of one channel are never high together; no pulse without a STATE change.
- Long-press counter (24 bits, macro only): cleared while STATE = 0; increments while STATE = 1, saturating at LONG_CYCLES-1; LONG pulses once on the cycle it reaches LONG_CYCLES-1. At most one LONG per press; a new press requires a release first.
- Reset (any time, including mid-debounce or mid-hold): all flops and counters cleared immediately; STATE, PRESS, RELEASE, LONG, LED all 0. A switch held through reset is accepted as a new press DB_CYCLES+2 edges after RESET_N deasserts, with PRESS pulse.

## Timing
- All outputs registered; no combinational path from SW to any output.
- Latency: raw change captured on edge 0 (setup met) -> STATE, PRESS/RELEASE, LED change on edge DB_CYCLES+1 (DB_CYCLES+2 edges total), provided the input stays stable.
- LONG: asserted LONG_CYCLES-1 edges after the edge on which STATE rose.
- Asynchronous reset assertion clears outputs without a clock; release is synchronised externally by the board reset logic.

## Configuration
- LONG_PRESS_EN defined: long-press counters present; LONG1/LONG2 behave as above.
- LONG_PRESS_EN undefined: no long-press counters synthesised; LONG1/LONG2 tied to 0; LONG_CYCLES ignored.

## Test plan
All scenarios use DB_CYCLES=8 and LONG_CYCLES=32.
- SW1 1->0 held -> STATE1=LED1=1 and PRESS1 for one cycle, exactly 10 edges after capture; STATE2 stays 0.
- SW1 pulsed low for 7 cycles, repeated 5 times with 1-cycle highs -> STATE1 stays 0, no PRESS1/RELEASE1.
- Press accepted, then SW1 released -> RELEASE1 for one cycle 10 edges later, STATE1=0.
- Both SW1 and SW2 pressed on the same edge -> PRESS1 and PRESS2 asserted on the same cycle.
- RESET_N pulsed low at counter=5 while SW1 low -> outputs 0 at once; PRESS1 occurs 10 edges after reset release.
- With LONG_PRESS_EN, SW1 held -> exactly one LONG1 pulse 31 edges after STATE1 rises; without the macro, LONG1 stays 0 throughout.
